// File: rtl/snake_move_ctrl_if.sv
// Bundle of the snake movement engine's control inputs and renderer/food-generator outputs.
interface snake_move_ctrl_if #(
    parameter int XW = 5,
    parameter int YW = 5,
    parameter int LW = 5
);
    logic          tick_in;
    logic          start;
    logic          pause;
    logic          dir_valid;
    logic [1:0]    dir_req;
    logic [XW-1:0] food_x;
    logic [YW-1:0] food_y;
    logic [LW-1:0] rd_idx;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [LW-1:0] snake_len;
    logic [1:0]    state;
    logic          ate;
    logic          step_done;

    modport master (
        output tick_in, start, pause, dir_valid, dir_req, food_x, food_y, rd_idx,
        input  rd_x, rd_y, head_x, head_y, snake_len, state, ate, step_done
    );

    modport slave (
        input  tick_in, start, pause, dir_valid, dir_req, food_x, food_y, rd_idx,
        output rd_x, rd_y, head_x, head_y, snake_len, state, ate, step_done
    );
endinterface

// File: rtl/snake_move_ctrl.sv
// Snake movement engine: steps once per divider toggle on a wrapping grid,
// with no-reverse steering, growth on food and self-collision detection.
module snake_move_ctrl #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int XW       = 5,
    parameter int YW       = 5,
    parameter int LW       = 5
) (
    input logic             clk,
    input logic             rst,
    snake_move_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;
    typedef enum logic [1:0] {UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3} dir_t;

    state_t        st, st_nxt;
    dir_t          cur_dir, pend_dir, dir_ref;
    logic          s1, s2, s3;
    logic          step_evt, do_step, dir_ok;
    logic [XW-1:0] seg_x [MAX_LEN];
    logic [YW-1:0] seg_y [MAX_LEN];
    logic [LW-1:0] len, lim;
    logic [XW-1:0] nx, rd_x_c;
    logic [YW-1:0] ny, rd_y_c;
    logic          grow, grow_inc, hit;
    logic          ate_r, done_r;

    assign step_evt = s2 ^ s3;
    // start and pause both pre-empt a step landing in the same cycle
    assign do_step  = step_evt && (st == RUN) && !bus.start && !bus.pause;
    assign dir_ref  = do_step ? pend_dir : cur_dir;
    assign dir_ok   = bus.dir_valid && (bus.dir_req != (dir_ref ^ 2'd2));

    always_comb begin
        nx = seg_x[0];
        ny = seg_y[0];
        case (pend_dir)
            UP:      ny = (seg_y[0] == '0) ? YW'(GRID_H - 1) : seg_y[0] - YW'(1);
            DOWN:    ny = (seg_y[0] == YW'(GRID_H - 1)) ? '0 : seg_y[0] + YW'(1);
            LEFT:    nx = (seg_x[0] == '0) ? XW'(GRID_W - 1) : seg_x[0] - XW'(1);
            default: nx = (seg_x[0] == XW'(GRID_W - 1)) ? '0 : seg_x[0] + XW'(1);
        endcase
    end

    // The tail cell is vacated on a non-growing step, so it only counts when the length increments
    assign grow     = (nx == bus.food_x) && (ny == bus.food_y);
    assign grow_inc = grow && (len < LW'(MAX_LEN));
    assign lim      = grow_inc ? len : len - LW'(1);

    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < lim) && (seg_x[i] == nx) && (seg_y[i] == ny)) hit = 1'b1;
        end
    end

    always_comb begin
        st_nxt = st;
        if (bus.start) begin
            st_nxt = RUN;
        end else begin
            case (st)
                RUN:     if (bus.pause) st_nxt = PAUSE;
                         else if (do_step && hit) st_nxt = OVER;
                PAUSE:   if (bus.pause) st_nxt = RUN;
                default: st_nxt = st;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            cur_dir  <= RIGHT;
            pend_dir <= RIGHT;
            len      <= LW'(INIT_LEN);
            ate_r    <= 1'b0;
            done_r   <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? XW'(GRID_W / 2 - int'(i)) : '0;
                seg_y[i] <= (i < INIT_LEN) ? YW'(GRID_H / 2) : '0;
            end
        end else begin
            s1     <= bus.tick_in;
            s2     <= s1;
            s3     <= s2;
            ate_r  <= 1'b0;
            done_r <= 1'b0;
            if (bus.start) begin
                cur_dir  <= RIGHT;
                pend_dir <= RIGHT;
                len      <= LW'(INIT_LEN);
                for (int unsigned i = 0; i < MAX_LEN; i++) begin
                    seg_x[i] <= (i < INIT_LEN) ? XW'(GRID_W / 2 - int'(i)) : '0;
                    seg_y[i] <= (i < INIT_LEN) ? YW'(GRID_H / 2) : '0;
                end
            end else begin
                if (dir_ok) pend_dir <= dir_t'(bus.dir_req);
                if (do_step) begin
                    cur_dir <= pend_dir;
                    done_r  <= 1'b1;
                    if (!hit) begin
                        seg_x[0] <= nx;
                        seg_y[0] <= ny;
                        for (int unsigned i = 1; i < MAX_LEN; i++) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        if (grow_inc) len <= len + LW'(1);
                        ate_r <= grow;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_x_c = '0;
        rd_y_c = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) == bus.rd_idx) && (LW'(i) < len)) begin
                rd_x_c = seg_x[i];
                rd_y_c = seg_y[i];
            end
        end
    end

    assign bus.rd_x      = rd_x_c;
    assign bus.rd_y      = rd_y_c;
    assign bus.head_x    = seg_x[0];
    assign bus.head_y    = seg_y[0];
    assign bus.snake_len = len;
    assign bus.state     = st;
    assign bus.ate       = ate_r;
    assign bus.step_done = done_r;
endmodule
